// File: rtl/mc_pkg.sv
// mc_pkg: shared states, opcode/funct encodings, ALU and PC-source codes for the multicycle controller.
package mc_pkg;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR} state_t;
    typedef enum logic [3:0] {OP_ADD, OP_SUB, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ILL} op_t;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LUI   = 6'h19;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] FN_ADD    = 6'h20;
    localparam logic [5:0] FN_SUB    = 6'h22;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_LUI = 2'b11;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    function automatic logic [1:0] alu_op_of(input op_t op);
        return op == OP_ORI ? ALU_OR :
               (op == OP_SUB || op == OP_BEQ) ? ALU_SUB :
               op == OP_LUI ? ALU_LUI : ALU_ADD;
    endfunction

    function automatic logic imm_of(input op_t op);
        return op == OP_ORI || op == OP_LUI || op == OP_LW || op == OP_SW;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode/funct classification; anything unlisted maps to OP_ILL.
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0] instr,
    output op_t         op
);

    logic [5:0] opc;
    logic [5:0] fn;
    logic       unused_bits;

    assign opc         = instr[31:26];
    assign fn          = instr[5:0];
    assign unused_bits = ^instr[25:6];

    assign op = opc == OPC_RTYPE ? (fn == FN_ADD ? OP_ADD : fn == FN_SUB ? OP_SUB : OP_ILL) :
                opc == OPC_ORI   ? OP_ORI :
                opc == OPC_LUI   ? OP_LUI :
                opc == OPC_LW    ? OP_LW  :
                opc == OPC_SW    ? OP_SW  :
                opc == OPC_BEQ   ? OP_BEQ :
                opc == OPC_J     ? OP_J   : OP_ILL;

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle CPU control FSM with memory-wait timeout and sticky error state.
// Optional MC_PERF_CNT_EN adds free-running cycle and retired-instruction counters.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_seq,
    input  logic        run,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_op,
    output logic        alu_src_imm,
    output logic        reg_write,
    output logic        reg_dst_rd,
    output logic        mem2reg,
    output logic        busy,
    output logic        err
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retired_cnt
`endif
);

    state_t      state;
    state_t      after;
    op_t         op;
    op_t         dec;
    logic [15:0] wait_cnt;
    logic        ready;
    logic        at_limit;
    logic        jump;
    logic        branch;
    logic        in_alu;

    mc_decode u_decode (.instr(instr), .op(dec));

    assign ready    = state == S_MEM ? dmem_ready : imem_ready;
    // Limit is hit on the MEM_TIMEOUT-th waiting cycle; ready in that cycle still wins.
    assign at_limit = wait_cnt == 16'(MEM_TIMEOUT - 1);
    assign after    = run ? S_FETCH : S_IDLE;

    always_ff @(posedge clk) begin
        if (rst_seq) begin
            state    <= S_IDLE;
            op       <= OP_ILL;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= ((state == S_FETCH || state == S_MEM) && !ready) ? wait_cnt + 16'd1 : '0;
            case (state)
                S_IDLE:   state <= after;
                S_FETCH:  state <= imem_ready ? S_DECODE : at_limit ? S_ERR : S_FETCH;
                S_DECODE: begin
                    op    <= dec;
                    state <= dec == OP_ILL ? S_ERR : dec == OP_J ? after : S_EXEC;
                end
                S_EXEC:   state <= op == OP_BEQ ? after : (op == OP_LW || op == OP_SW) ? S_MEM : S_WB;
                S_MEM:    state <= dmem_ready ? (op == OP_SW ? after : S_WB) : at_limit ? S_ERR : S_MEM;
                S_WB:     state <= after;
                default:  state <= S_ERR;
            endcase
        end
    end

    assign jump        = state == S_DECODE && dec == OP_J;
    assign branch      = state == S_EXEC && op == OP_BEQ;
    assign in_alu      = state == S_EXEC || state == S_MEM;
    assign imem_req    = state == S_FETCH;
    assign ir_write    = imem_req && imem_ready;
    assign pc_write    = ir_write || jump || (branch && alu_zero);
    assign pc_src      = jump ? PC_JUMP : branch ? PC_BRANCH : PC_SEQ;
    assign alu_op      = in_alu ? alu_op_of(op) : ALU_ADD;
    assign alu_src_imm = in_alu && imm_of(op);
    assign dmem_req    = state == S_MEM;
    assign dmem_we     = dmem_req && op == OP_SW;
    assign reg_write   = state == S_WB;
    assign reg_dst_rd  = reg_write && (op == OP_ADD || op == OP_SUB);
    assign mem2reg     = reg_write && op == OP_LW;
    assign busy        = state != S_IDLE && state != S_ERR;
    assign err         = state == S_ERR;

`ifdef MC_PERF_CNT_EN
    logic done;

    assign done = jump || branch || (state == S_MEM && dmem_ready && op == OP_SW) || state == S_WB;

    always_ff @(posedge clk) begin
        if (rst_seq) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            cycle_cnt   <= cycle_cnt + 32'd1;
            retired_cnt <= retired_cnt + 32'(done);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-cycle scoreboard of expected control vectors for each instruction scenario.
module tb_multicycle_ctrl;

    typedef enum {K_ADD, K_SUB, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_ILL} kind_t;

    typedef struct {
        logic [31:0] word;
        logic        ir;
        logic        dr;
        logic        z;
        logic        rn;
        logic        rs;
        logic [14:0] exp;
    } item_t;

    logic        clk = 0;
    logic        rst_seq = 1;
    logic        run = 0;
    logic [31:0] instr = '0;
    logic        alu_zero = 0;
    logic        imem_ready = 0;
    logic        dmem_ready = 0;
    logic        imem_req, dmem_req, dmem_we, ir_write, pc_write;
    logic [1:0]  pc_src, alu_op;
    logic        alu_src_imm, reg_write, reg_dst_rd, mem2reg, busy, err;

    item_t q[$];
    string tags[$];
    int    n_chk = 0;
    int    n_pass = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_seq(rst_seq), .run(run), .instr(instr), .alu_zero(alu_zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_op(alu_op), .alu_src_imm(alu_src_imm), .reg_write(reg_write),
        .reg_dst_rd(reg_dst_rd), .mem2reg(mem2reg), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] mk(input logic imr, dmr, dwe, irw, pcw, input logic [1:0] ps, ao,
                                       input logic imm, rw, rd, m2r, bsy, er);
        return {imr, dmr, dwe, irw, pcw, ps, ao, imm, rw, rd, m2r, bsy, er};
    endfunction

    function automatic logic [14:0] obs();
        return {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, alu_op,
                alu_src_imm, reg_write, reg_dst_rd, mem2reg, busy, err};
    endfunction

    task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%b exp=%b", tag, got, exp);
    endtask

    task automatic push(input string tag, input logic [31:0] w, input logic ir, dr, z, rn, rs,
                        input logic [14:0] e);
        item_t it;
        it.word = w; it.ir = ir; it.dr = dr; it.z = z; it.rn = rn; it.rs = rs; it.exp = e;
        q.push_back(it);
        tags.push_back(tag);
    endtask

    task automatic push_err(input string nm, input logic [31:0] w);
        for (int i = 0; i < 2; i++) push({nm, ":err"}, w, 1, 1, 0, 1, 0, mk(0,0,0,0,0,2'b00,2'b00,0,0,0,0,0,1));
    endtask

    task automatic tail(input string nm, input logic [31:0] w, input logic run_end);
        if (!run_end) push({nm, ":idle_after"}, w, 0, 0, 0, 0, 0, '0);
    endtask

    // Expected per-cycle vectors derived from the instruction class and the memory delays.
    task automatic sched(input string nm, input kind_t k, input logic [31:0] w, input int fd, input int dd,
                         input logic z, input logic lead, input logic run_end);
        logic [1:0]  ao;
        logic        imm;
        logic        sw;
        logic [14:0] busy_only;
        logic [14:0] mem_v;
        ao = k == K_ORI ? 2'b01 : (k == K_SUB || k == K_BEQ) ? 2'b10 : k == K_LUI ? 2'b11 : 2'b00;
        imm = k == K_ORI || k == K_LUI || k == K_LW || k == K_SW;
        sw = k == K_SW;
        busy_only = mk(0,0,0,0,0,2'b00,2'b00,0,0,0,0,1,0);
        if (lead) push({nm, ":idle"}, w, 0, 0, 0, 1, 0, '0);
        for (int i = 0; i < (fd < 4 ? fd : 4); i++)
            push({nm, ":fetch_wait"}, w, 0, 0, 0, 0, 0, mk(1,0,0,0,0,2'b00,2'b00,0,0,0,0,1,0));
        if (fd >= 4) begin push_err(nm, w); return; end
        push({nm, ":fetch"}, w, 1, 0, 0, 0, 0, mk(1,0,0,1,1,2'b00,2'b00,0,0,0,0,1,0));
        if (k == K_ILL) begin
            push({nm, ":decode"}, w, 0, 0, 0, 0, 0, busy_only);
            push_err(nm, w);
            return;
        end
        if (k == K_J) begin
            push({nm, ":decode"}, w, 0, 0, 0, run_end, 0, mk(0,0,0,0,1,2'b10,2'b00,0,0,0,0,1,0));
            tail(nm, w, run_end);
            return;
        end
        push({nm, ":decode"}, w, 0, 0, 0, 0, 0, busy_only);
        if (k == K_BEQ) begin
            push({nm, ":exec"}, w, 0, 0, z, run_end, 0, mk(0,0,0,0,z,2'b01,ao,imm,0,0,0,1,0));
            tail(nm, w, run_end);
            return;
        end
        push({nm, ":exec"}, w, 0, 0, 0, 0, 0, mk(0,0,0,0,0,2'b00,ao,imm,0,0,0,1,0));
        if (k == K_LW || k == K_SW) begin
            mem_v = mk(0,1,sw,0,0,2'b00,ao,imm,0,0,0,1,0);
            for (int i = 0; i < (dd < 4 ? dd : 4); i++) push({nm, ":mem_wait"}, w, 0, 0, 0, 0, 0, mem_v);
            if (dd >= 4) begin push_err(nm, w); return; end
            push({nm, ":mem"}, w, 0, 1, 0, sw ? run_end : 1'b0, 0, mem_v);
            if (sw) begin tail(nm, w, run_end); return; end
        end
        push({nm, ":wb"}, w, 0, 0, 0, run_end, 0,
             mk(0,0,0,0,0,2'b00,2'b00,0,1,k == K_ADD || k == K_SUB,k == K_LW,1,0));
        tail(nm, w, run_end);
    endtask

    task automatic drain();
        item_t it;
        string tg;
        while (q.size() > 0) begin
            it = q.pop_front();
            tg = tags.pop_front();
            @(negedge clk);
            instr = it.word; imem_ready = it.ir; dmem_ready = it.dr;
            alu_zero = it.z; run = it.rn; rst_seq = it.rs;
            #1 check(tg, obs(), it.exp);
        end
    endtask

    task automatic do_reset(input string tg);
        @(negedge clk);
        rst_seq = 1; run = 1; imem_ready = 1; dmem_ready = 1;
        @(negedge clk);
        rst_seq = 0; run = 0;
        #1 check(tg, obs(), '0);
    endtask

    logic [31:0] w_add, w_sub, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_ill, w_badfn;

    initial begin
        w_add   = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
        w_sub   = {6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'h22};
        w_ori   = {6'h0D, 5'd1, 5'd7, 16'h00FF};
        w_lui   = {6'h19, 5'd0, 5'd8, 16'h1234};
        w_lw    = {6'h23, 5'd1, 5'd9, 16'h0010};
        w_sw    = {6'h2B, 5'd1, 5'd2, 16'h0008};
        w_beq   = {6'h04, 5'd1, 5'd2, 16'hFFFE};
        w_j     = {6'h02, 26'h0000100};
        w_ill   = {6'h3F, 26'h0};
        w_badfn = {6'h00, 20'h0, 6'h21};

        do_reset("reset");
        sched("add", K_ADD, w_add, 0, 0, 0, 1, 0);      drain();
        sched("sub", K_SUB, w_sub, 2, 0, 0, 1, 0);      drain();
        sched("ori_f3", K_ORI, w_ori, 3, 0, 0, 1, 0);   drain();
        sched("lui", K_LUI, w_lui, 0, 0, 0, 1, 0);      drain();
        sched("lw_d3", K_LW, w_lw, 0, 3, 0, 1, 0);      drain();
        sched("sw", K_SW, w_sw, 0, 0, 0, 1, 0);         drain();
        sched("sw_d2", K_SW, w_sw, 0, 2, 0, 1, 0);      drain();
        sched("beq_z1", K_BEQ, w_beq, 0, 0, 1, 1, 0);   drain();
        sched("beq_z0", K_BEQ, w_beq, 0, 0, 0, 1, 0);   drain();
        sched("j_chain", K_J, w_j, 0, 0, 0, 1, 1);      drain();
        sched("add_after_j", K_ADD, w_add, 1, 0, 0, 0, 1); drain();
        sched("lw_after_add", K_LW, w_lw, 0, 0, 0, 0, 0);  drain();
        sched("ill_3f", K_ILL, w_ill, 0, 0, 0, 1, 0);   drain();
        do_reset("ill_reset");
        sched("bad_funct", K_ILL, w_badfn, 0, 0, 0, 1, 0); drain();
        do_reset("badfn_reset");
        sched("fetch_timeout", K_ADD, w_add, 4, 0, 0, 1, 0); drain();
        do_reset("fetch_to_reset");
        sched("mem_timeout", K_LW, w_lw, 0, 4, 0, 1, 0); drain();
        do_reset("mem_to_reset");

        push("sw_rst:idle", w_sw, 0, 0, 0, 1, 0, '0);
        push("sw_rst:fetch", w_sw, 1, 0, 0, 0, 0, mk(1,0,0,1,1,2'b00,2'b00,0,0,0,0,1,0));
        push("sw_rst:decode", w_sw, 0, 0, 0, 0, 0, mk(0,0,0,0,0,2'b00,2'b00,0,0,0,0,1,0));
        push("sw_rst:exec", w_sw, 0, 0, 0, 0, 0, mk(0,0,0,0,0,2'b00,2'b00,1,0,0,0,1,0));
        push("sw_rst:mem", w_sw, 0, 0, 0, 0, 0, mk(0,1,1,0,0,2'b00,2'b00,1,0,0,0,1,0));
        push("sw_rst:mem_rst", w_sw, 0, 0, 0, 0, 1, mk(0,1,1,0,0,2'b00,2'b00,1,0,0,0,1,0));
        push("sw_rst:idle_after", w_sw, 0, 1, 0, 0, 0, '0);
        push("sw_rst:idle_hold", w_sw, 0, 1, 0, 0, 0, '0);
        drain();

        sched("add_final", K_ADD, w_add, 0, 0, 0, 1, 0); drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
